// File: rtl/frame_stream_out_pkg.sv
// Shared types for the frame playback path: FSM state and FIFO entry layout.
package frame_stream_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // One buffered pixel: BRAM read data plus its stream framing tags.
  typedef struct packed {
    logic data;
    logic sof;
    logic eol;
  } pix_entry_t;

  localparam int unsigned ENTRY_W = $bits(pix_entry_t);

endpackage

// File: rtl/frame_stream_out_stream_fifo.sv
// Small synchronous FIFO with a registered head (storage read directly).
module frame_stream_out_stream_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned DW    = 3,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage write; contents need no reset since empty gates the head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr_q];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/frame_stream_out.sv
// Replays a 1-bit frame from BRAM as an AXI4-Stream video stream.
module frame_stream_out
  import frame_stream_out_pkg::*;
#(
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned WIDTH                  = 4,
  parameter int unsigned HEIGHT                 = 2,
  parameter int unsigned ADDR_WIDTH             = 32,
  parameter int unsigned BRAM_LATENCY           = 2
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  input  logic                                  s00_start_playback,
  output logic                                  m00_busy,
  output logic                                  m00_done,
  output logic                                  m00_bram_en,
  output logic [ADDR_WIDTH-1:0]                 m00_bram_address,
  input  logic                                  s00_bram_data,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  output logic                                  m00_axis_tuser
);

  localparam int unsigned FIFO_DEPTH = BRAM_LATENCY + 2;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_X    = ADDR_WIDTH'(WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_Y    = ADDR_WIDTH'(HEIGHT - 1);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, last_addr_q, x_q, y_q, line_out_q;
  logic [BRAM_LATENCY-1:0] vld_q;
  logic [1:0]              tag_q [BRAM_LATENCY];

  logic [CW-1:0] in_flight, fifo_count;
  logic [CW:0]   credit_used;
  logic          fifo_full, fifo_empty, issue, last_issue, pop, last_pop;
  logic          sof, eol, done_q;
  pix_entry_t    push_entry, head;
  logic [ENTRY_W-1:0] head_bits;

  assign sof = (x_q == '0) && (y_q == '0);
  assign eol = (x_q == LAST_X);

  // Reads still travelling through the BRAM pipeline.
  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < BRAM_LATENCY; i++) begin
      in_flight = in_flight + CW'(vld_q[i]);
    end
  end

  // Issue only when every outstanding read is guaranteed a FIFO slot.
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign issue       = (state_q == ST_STREAM) && !fifo_full &&
                       (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign last_issue  = issue && (addr_q == LAST_ADDR);
  assign pop         = !fifo_empty && m00_axis_tready;
  assign last_pop    = pop && head.eol && (line_out_q == LAST_Y);

  // State register.
  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  // Next-state logic; start pulses outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (s00_start_playback) state_d = ST_STREAM;
      ST_STREAM: if (last_issue)         state_d = ST_DRAIN;
      ST_DRAIN:  if (last_pop)           state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Address, column/line counters and output-line counter; all held at 0 in IDLE.
  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn || state_q == ST_IDLE) begin
      addr_q      <= '0;
      last_addr_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      line_out_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= last_pop;
      if (issue) begin
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        last_addr_q <= addr_q;
        if (eol) begin
          x_q <= '0;
          y_q <= y_q + ADDR_WIDTH'(1);
        end else begin
          x_q <= x_q + ADDR_WIDTH'(1);
        end
      end
      if (pop && head.eol) line_out_q <= line_out_q + ADDR_WIDTH'(1);
    end
  end

  // Valid/tag shift register aligned with BRAM read latency.
  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < BRAM_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      tag_q[0] <= {sof, eol};
      for (int unsigned i = 1; i < BRAM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Returned data joined with its tags.
  always_comb begin
    push_entry      = '0;
    push_entry.data = s00_bram_data;
    push_entry.sof  = tag_q[BRAM_LATENCY-1][1];
    push_entry.eol  = tag_q[BRAM_LATENCY-1][0];
  end

  frame_stream_out_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (ENTRY_W)
  ) u_fifo (
    .clk       (m00_axis_aclk),
    .rst_n     (m00_axis_aresetn),
    .push      (vld_q[BRAM_LATENCY-1]),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_bits),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head = pix_entry_t'(head_bits);

  // Stream and control outputs; payload gated to zero while no beat is offered.
  always_comb begin
    m00_axis_tvalid   = !fifo_empty;
    m00_axis_tdata    = '0;
    m00_axis_tdata[0] = !fifo_empty && head.data;
    m00_axis_tuser    = !fifo_empty && head.sof;
    m00_axis_tlast    = !fifo_empty && head.eol;
    m00_axis_tstrb    = '1;
    m00_bram_en       = issue;
    m00_bram_address  = (state_q == ST_IDLE) ? '0 : (issue ? addr_q : last_addr_q);
    m00_busy          = (state_q != ST_IDLE);
    m00_done          = done_q;
  end

endmodule
